// File: rtl/fastreadout_packet_rx.sv
`timescale 1ns/1ps
// fastreadout_packet_rx: receive-side deframer for the fastreadout byte stream.
// Hunts for SYNC, parses HDR, buffers up to 16 payload bytes, checks the
// additive checksum and releases good payloads on a valid/ready output.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   rx_data/valid   incoming stream byte (no backpressure)
//   out_ready       downstream accepts out_data
//   out_data/valid  released payload byte
//   out_last        final payload byte of the packet
//   out_channel     channel id of the packet being released
//   pkt_ok/pkt_err  one-cycle checksum match / mismatch pulses
//   rx_drop         rx byte discarded while draining
//   err_count       saturating checksum error count
//   busy            deframer not hunting for sync
module fastreadout_packet_rx #(
    parameter logic [7:0] SYNC   = 8'hA5,
    parameter int         MAXLEN = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    output logic [3:0] out_channel,
    output logic       pkt_ok,
    output logic       pkt_err,
    output logic       rx_drop,
    output logic [7:0] err_count,
    output logic       busy
);

    localparam logic [2:0] S_HUNT  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_PAY   = 3'd2;
    localparam logic [2:0] S_CHK   = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0] state;
    logic [3:0] chan;
    logic [3:0] len;
    logic [3:0] wr_ptr;
    logic [3:0] rd_ptr;
    logic [7:0] sum;
    logic [7:0] pbuf [MAXLEN];

    // Length code 0 means 16 bytes; len-1 wraps to 15, so
    // the final index is simply len-1 in 4-bit arithmetic.
    logic [3:0] last_idx;
    assign last_idx = len - 4'd1;

    logic draining;
    assign draining = (state == S_DRAIN);

    logic xfer;
    assign xfer = draining && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_HUNT;
            chan      <= 4'd0;
            len       <= 4'd0;
            wr_ptr    <= 4'd0;
            rd_ptr    <= 4'd0;
            sum       <= 8'd0;
            pkt_ok    <= 1'b0;
            pkt_err   <= 1'b0;
            err_count <= 8'd0;
        end else begin
            pkt_ok  <= 1'b0;
            pkt_err <= 1'b0;
            unique case (state)
                S_HUNT: begin
                    if (rx_valid && rx_data == SYNC)
                        state <= S_HDR;
                end
                S_HDR: begin
                    // No resync: a SYNC value here is a header.
                    if (rx_valid) begin
                        chan   <= rx_data[7:4];
                        len    <= rx_data[3:0];
                        sum    <= rx_data;
                        wr_ptr <= 4'd0;
                        state  <= S_PAY;
                    end
                end
                S_PAY: begin
                    if (rx_valid) begin
                        sum    <= sum + rx_data;
                        wr_ptr <= wr_ptr + 4'd1;
                        if (wr_ptr == last_idx)
                            state <= S_CHK;
                    end
                end
                S_CHK: begin
                    if (rx_valid) begin
                        if (rx_data == sum) begin
                            pkt_ok <= 1'b1;
                            rd_ptr <= 4'd0;
                            state  <= S_DRAIN;
                        end else begin
                            pkt_err <= 1'b1;
                            if (err_count != 8'hFF)
                                err_count <= err_count + 8'd1;
                            state <= S_HUNT;
                        end
                    end
                end
                S_DRAIN: begin
                    if (xfer) begin
                        rd_ptr <= rd_ptr + 4'd1;
                        if (rd_ptr == last_idx)
                            state <= S_HUNT;
                    end
                end
                default: state <= S_HUNT;
            endcase
        end
    end

    // Payload storage needs no reset; contents are
    // only read back after a complete good frame.
    always_ff @(posedge clk) begin
        if (state == S_PAY && rx_valid)
            pbuf[wr_ptr] <= rx_data;
    end

    // Outputs are gated by DRAIN so they read 0 whenever
    // nothing is being presented.
    assign out_valid   = draining;
    assign out_data    = draining ? pbuf[rd_ptr] : 8'd0;
    assign out_channel = draining ? chan : 4'd0;
    assign out_last    = draining && (rd_ptr == last_idx);
    assign rx_drop     = draining && rx_valid;
    assign busy        = (state != S_HUNT);

endmodule

// File: tb/tb_fastreadout_packet_rx.sv
`timescale 1ns/1ps
// tb_fastreadout_packet_rx: directed frames with a scoreboard of
// expected output bytes checked by an independent monitor.
module tb_fastreadout_packet_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic [3:0] out_channel;
    logic       pkt_ok;
    logic       pkt_err;
    logic       rx_drop;
    logic [7:0] err_count;
    logic       busy;

    always #5 clk = ~clk;

    fastreadout_packet_rx dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_last(out_last),
        .out_channel(out_channel),
        .pkt_ok(pkt_ok),
        .pkt_err(pkt_err),
        .rx_drop(rx_drop),
        .err_count(err_count),
        .busy(busy)
    );

    typedef struct packed {
        logic [3:0] ch;
        logic [7:0] d;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ok_cnt = 0;
    int   err_cnt = 0;
    int   drop_cnt = 0;
    logic hold_v = 1'b0;
    exp_t hold_val;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    // Monitor: samples on the falling edge, between clock edges.
    always @(negedge clk) begin
        exp_t cur;
        exp_t e;
        cur = '{ch: out_channel, d: out_data, last: out_last};
        if (pkt_ok) begin
            ok_cnt++;
            check("ok_with_valid", 32'(out_valid), 32'd1);
        end
        if (pkt_err) begin
            err_cnt++;
            check("err_no_valid", 32'(out_valid), 32'd0);
        end
        if (rx_drop) drop_cnt++;
        if (out_valid) begin
            if (hold_v) check("hold_stable", 32'(cur), 32'(hold_val));
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out: got %0h, want none",
                             cur);
                end else begin
                    e = exp_q.pop_front();
                    check("out_byte", 32'(cur), 32'(e));
                end
                hold_v = 1'b0;
            end else begin
                hold_v   = 1'b1;
                hold_val = cur;
            end
        end else begin
            hold_v = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic expect_out(input logic [3:0] ch,
                              input logic [7:0] d,
                              input logic last);
        exp_q.push_back('{ch: ch, d: d, last: last});
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 300; i++) begin
            if (!busy && exp_q.size() == 0) break;
            tick();
        end
        tick();
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_counts(input string name,
                                input int ok_e,
                                input int err_e,
                                input int drop_e);
        check({name, "_ok"}, 32'(ok_cnt), 32'(ok_e));
        check({name, "_err"}, 32'(err_cnt), 32'(err_e));
        check({name, "_drop"}, 32'(drop_cnt), 32'(drop_e));
        ok_cnt   = 0;
        err_cnt  = 0;
        drop_cnt = 0;
    endtask

    task automatic good_pkt();
        expect_out(4'h2, 8'h10, 1'b0);
        expect_out(4'h2, 8'h20, 1'b0);
        expect_out(4'h2, 8'h30, 1'b1);
        send(8'hA5); send(8'h23); send(8'h10);
        send(8'h20); send(8'h30); send(8'h83);
    endtask

    task automatic check_zero_outs(input string name);
        check({name, "_valid"}, 32'(out_valid), 32'd0);
        check({name, "_data"}, 32'(out_data), 32'd0);
        check({name, "_last"}, 32'(out_last), 32'd0);
        check({name, "_chan"}, 32'(out_channel), 32'd0);
        check({name, "_pulses"},
              32'({pkt_ok, pkt_err, rx_drop}), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        out_ready = 1'b1;
        repeat (3) tick();
        check_zero_outs("reset");
        check("reset_errcnt", 32'(err_count), 32'd0);
        rst_n = 1'b1;
        tick();

        // Good packet
        good_pkt();
        wait_idle("good_drain");
        check_counts("good", 1, 0, 0);
        check("good_errcnt", 32'(err_count), 32'd0);

        // Bad checksum, then good packet
        send(8'hA5); send(8'h23); send(8'h10);
        send(8'h20); send(8'h30); send(8'h84);
        check("bad_busy", 32'(busy), 32'd0);
        wait_idle("bad_drain");
        check_counts("bad", 0, 1, 0);
        check("bad_errcnt", 32'(err_count), 32'd1);
        good_pkt();
        wait_idle("after_bad_drain");
        check_counts("after_bad", 1, 0, 0);

        // Garbage before sync
        send(8'h00); send(8'hFF); send(8'h5A);
        check("garbage_busy", 32'(busy), 32'd0);
        expect_out(4'h5, 8'h7F, 1'b1);
        send(8'hA5); send(8'h51); send(8'h7F); send(8'hD0);
        wait_idle("garbage_drain");
        check_counts("garbage", 1, 0, 0);

        // Backpressure mid-drain
        for (int i = 1; i <= 4; i++)
            expect_out(4'h3, 8'(i), 1'(i == 4));
        send(8'hA5); send(8'h34);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'h3E);
        tick();
        out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
        wait_idle("bp_drain");
        check_counts("bp", 1, 0, 0);

        // Maximum length, length code 0
        for (int i = 1; i <= 16; i++)
            expect_out(4'h7, 8'(i), 1'(i == 16));
        send(8'hA5); send(8'h70);
        for (int i = 1; i <= 16; i++) send(8'(i));
        send(8'hF8);
        wait_idle("max_drain");
        check_counts("max", 1, 0, 0);

        // rx bytes during drain are dropped
        expect_out(4'h9, 8'hAA, 1'b0);
        expect_out(4'h9, 8'h55, 1'b1);
        out_ready = 1'b0;
        send(8'hA5); send(8'h92); send(8'hAA);
        send(8'h55); send(8'h91);
        send(8'hA5); send(8'h00); send(8'h12);
        check("drain_hold_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        wait_idle("drop_drain");
        check_counts("drop", 1, 0, 3);

        // Reset mid-drain
        out_ready = 1'b0;
        send(8'hA5); send(8'h12); send(8'h0F);
        send(8'h0E); send(8'h2F);
        tick();
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        check_zero_outs("mid_rst");
        check("mid_rst_errcnt", 32'(err_count), 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        check_counts("pre_rst", 1, 0, 0);

        // Delivery still works after reset
        good_pkt();
        wait_idle("post_rst_drain");
        check_counts("post_rst", 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
